// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
// The ALUCTRL_* codes are also consumed by the ALU control decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUCTRL_FUNCT = 2'b00;
    localparam logic [1:0] ALUCTRL_ADD   = 2'b01;
    localparam logic [1:0] ALUCTRL_SUB   = 2'b10;
    localparam logic [1:0] ALUCTRL_NOP   = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
        logic       i_or_d;
        logic       alu_src_a;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_ctrl;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_known(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: state (plus mem_ready, and opcode for the DECODE
// illegal check) to every datapath control line.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t      state,
    input  logic        mem_ready,
    input  logic [5:0]  opcode,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl          = '0;
        ctrl.alu_ctrl = ALUCTRL_NOP;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_ctrl  = ALUCTRL_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // ALU speculatively forms the branch target during decode
                ctrl.alu_src_b  = 2'b11;
                ctrl.alu_ctrl   = ALUCTRL_ADD;
                ctrl.illegal_op = !op_known(opcode);
                ctrl.instr_done = !op_known(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_ctrl  = ALUCTRL_ADD;
            end
            S_MEMRD: ctrl.i_or_d = 1'b1;
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_ctrl  = ALUCTRL_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b00;
                ctrl.alu_ctrl   = ALUCTRL_SUB;
                ctrl.branch     = 1'b1;
                ctrl.pc_src     = 2'b01;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_ctrl  = ALUCTRL_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JEX: begin
                ctrl.pc_src     = 2'b10;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state logic,
// retired-instruction counter and reset gating of the write enables.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             branch,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             alu_src_a,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_ctrl,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    state_t state, state_nxt;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JEX;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_nxt = S_MEMRD;
                else if (opcode == OP_SW) state_nxt = S_MEMWR;
                else                      state_nxt = S_FETCH;
            end
            S_MEMRD:   state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_nxt = S_RTYPEWB;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            default:   state_nxt = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    // Enables are gated so nothing writes while reset is held; selects pass
    // through and show FETCH values because the state is already FETCH.
    assign ir_write   = rst_n & ctrl.ir_write;
    assign mem_write  = rst_n & ctrl.mem_write;
    assign reg_write  = rst_n & ctrl.reg_write;
    assign pc_write   = rst_n & ctrl.pc_write;
    assign pc_en      = rst_n & (ctrl.pc_write | (ctrl.branch & zero));
    assign illegal_op = rst_n & ctrl.illegal_op;
    assign instr_done = rst_n & ctrl.instr_done;
    assign branch     = ctrl.branch;
    assign i_or_d     = ctrl.i_or_d;
    assign alu_src_a  = ctrl.alu_src_a;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign alu_ctrl   = ctrl.alu_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          instr_count <= '0;
        else if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end

endmodule
